prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Boot-time program loader upstream of the CPU's BRAM.
//  - Accepts a byte stream (UART/host side) over a valid/ready handshake.
//  - Assembles 16-bit words and writes them into BRAM through port B (addr_b/data_b/we_b).
//  - Holds the core in reset until a checksummed image has fully loaded, then releases it
//    via cpu_run, so the program counter starts fetching from BASE_ADDR.
// PARAMETERS
//  BASE_ADDR   16'h0000  BRAM word address of the first loaded word
//  DEPTH       1024      maximum image length in words; a longer header length is an error
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  reset       in   1   synchronous, active-low reset
//  load_start  in   1   1-cycle pulse; begins a load from IDLE, DONE or ERROR
//  byte_in     in   8   stream byte
//  byte_valid  in   1   byte_in is valid
//  byte_ready  out  1   loader accepts byte_in this cycle
//  addr_b      out  16  BRAM port B word address
//  data_b      out  16  BRAM port B write data
//  we_b        out  1   BRAM port B write enable
//  cpu_run     out  1   1 = core released from reset (image valid)
//  busy        out  1   load in progress
//  done        out  1   last load succeeded
//  err         out  1   last load failed (length overflow or checksum mismatch)
// BEHAVIOUR
//  Reset (reset==0 at a clk edge)
//  - State returns to IDLE.
//  - All outputs go to 0 (addr_b=0, data_b=0); index, count and checksum are cleared.
//  - A reset mid-load aborts the load. Words already written stay in BRAM, and cpu_run stays 0.
//  Handshake
//  - A byte is consumed on an edge where byte_valid && byte_ready.
//  - byte_ready is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK, and is driven from the registered state.
//  Stream format
//  - len[15:8], len[7:0], then len words each sent high byte first, then one checksum byte.
//  - The checksum is the XOR of every preceding byte, including both length bytes.
//  States
//  - IDLE: waits for load_start, then goes to LEN_HI; clears the checksum, sets index=0, cpu_run=0.
//  - LEN_HI / LEN_LO: capture len; both bytes are folded into the checksum.
//    - After LEN_LO: if len>DEPTH go to ERROR; if len==0 go to CHK; otherwise go to DATA_HI.
//  - DATA_HI: captures word[15:8].
//  - DATA_LO: captures word[7:0], then goes to WRITE.
//  - WRITE: a single cycle; byte_ready=0.
//    - Drives we_b=1, addr_b=BASE_ADDR+index (mod 2^16), data_b=word.
//    - Then index++; if the new index==len go to CHK, else go to DATA_HI.
//  - CHK: compares the received byte with the running XOR; equal goes to DONE, otherwise ERROR.
//  - DONE: done=1, cpu_run=1.
//  - ERROR: err=1, cpu_run=0.
//  - DONE and ERROR hold until load_start, which goes to LEN_HI. done, err and cpu_run clear on that
//    same edge, and the checksum and index are cleared.
//  Output rules
//  - busy=1 in every state except IDLE, DONE and ERROR.
//  - load_start is ignored while busy.
//  - we_b is never asserted outside WRITE. Each word is written exactly once.
//  - The minimum per-word latency is 3 cycles (DATA_HI, DATA_LO, WRITE).
//  - byte_valid gaps stall in the current state with no side effects.
// TESTING
//  1. Pulse load_start, send 00 02 12 34 AB CD 42
//     -> writes [BASE]=1234, [BASE+1]=ABCD, one we_b cycle each; then done=1, cpu_run=1, err=0.
//  2. Zero length: 00 00 00 -> DONE with no we_b pulse.
//     Then pulse load_start and send 00 00 FF -> ERROR, cpu_run drops to 0.
//  3. Bad checksum: 00 01 55 AA 00 -> one write of 55AA, then err=1, done=0, cpu_run=0.
//  4. Overflow: with DEPTH=1024, send 04 01 -> ERROR right after LEN_LO with no writes;
//     byte_ready=0 afterwards.
//  5. Stalls: case 1 with byte_valid low for 0-5 random cycles between bytes -> identical writes and
//     result; byte_ready=0 in every WRITE cycle.
//  6. Assert reset after the first word is written in case 1 -> IDLE, all outputs 0; a later
//     load_start plus the full case-1 stream succeeds.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length-prefixed, XOR-checksummed byte
// stream and writes 16-bit words into BRAM port B. The CPU is held in reset
// (cpu_run=0) until a complete image has loaded and its checksum matches.
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] addr_b,
  output logic [15:0] data_b,
  output logic        we_b,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  state_t      next_state;
  logic [15:0] len;
  logic [15:0] index;
  logic [15:0] word;
  logic [7:0]  chk;
  logic        fire;
  logic [15:0] len_next;
  logic [15:0] index_inc;
  logic        len_too_long;

  // Ready is a pure decode of the registered state, so it never depends on byte_valid.
  assign byte_ready = (state == S_LEN_HI)  || (state == S_LEN_LO) ||
                      (state == S_DATA_HI) || (state == S_DATA_LO) ||
                      (state == S_CHK);

  assign fire         = byte_valid && byte_ready;
  assign len_next     = {len[15:8], byte_in};
  assign len_too_long = {1'b0, len_next} > DEPTH_W;
  assign index_inc    = index + 16'd1;

  // State register; an active-low reset aborts any load in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode; the BRAM bus is only non-zero during WRITE.
  always_comb begin
    next_state = state;
    we_b       = 1'b0;
    addr_b     = 16'h0000;
    data_b     = 16'h0000;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    cpu_run    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (load_start) next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (fire) next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (fire) begin
          if (len_too_long)           next_state = S_ERROR;
          else if (len_next == 16'd0) next_state = S_CHK;
          else                        next_state = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (fire) next_state = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (fire) next_state = S_WRITE;
      end
      S_WRITE: begin
        we_b   = 1'b1;
        addr_b = BASE_ADDR + index;
        data_b = word;
        next_state = (index_inc == len) ? S_CHK : S_DATA_HI;
      end
      S_CHK: begin
        if (fire) next_state = (byte_in == chk) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        cpu_run = 1'b1;
        if (load_start) next_state = S_LEN_HI;
      end
      S_ERROR: begin
        busy = 1'b0;
        err  = 1'b1;
        if (load_start) next_state = S_LEN_HI;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, word index and running XOR checksum.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len   <= 16'h0000;
      index <= 16'h0000;
      word  <= 16'h0000;
      chk   <= 8'h00;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            len   <= 16'h0000;
            index <= 16'h0000;
            chk   <= 8'h00;
          end
        end
        S_LEN_HI: begin
          if (fire) begin
            len[15:8] <= byte_in;
            chk       <= chk ^ byte_in;
          end
        end
        S_LEN_LO: begin
          if (fire) begin
            len[7:0] <= byte_in;
            chk      <= chk ^ byte_in;
          end
        end
        S_DATA_HI: begin
          if (fire) begin
            word[15:8] <= byte_in;
            chk        <= chk ^ byte_in;
          end
        end
        S_DATA_LO: begin
          if (fire) begin
            word[7:0] <= byte_in;
            chk       <= chk ^ byte_in;
          end
        end
        S_WRITE: begin
          index <= index_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
